// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

  // The Memory-stage result is younger than Writeback, so it wins when both match.
  // R15 reads the PC, so it is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic [3:0] ra,
                                          input logic       we_m,
                                          input logic [3:0] wa_m,
                                          input logic       we_w,
                                          input logic [3:0] wa_w);
    if (we_m && wa_m == ra && ra != REG_PC)      return FWD_M;
    else if (we_w && wa_w == ra && ra != REG_PC) return FWD_W;
    else                                         return FWD_RF;
  endfunction

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating event counter with a synchronous clear that overrides counting.
module perf_counter_sat #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use and memory wait-state stalls, branch flushes,
// and stall/flush performance counters for the 5-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             PerfClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t state, state_nxt;
  logic [7:0] waitcnt, waitcnt_nxt;
  logic       err_set;
  logic       mem_stall;
  logic       ldr_stall;

  assign ForwardAE = fwd_select(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
  assign ForwardBE = fwd_select(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

  assign ldr_stall = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= M_IDLE;
      waitcnt <= '0;
      MemErr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      waitcnt <= waitcnt_nxt;
      MemErr  <= MemErr | err_set;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    waitcnt_nxt = waitcnt;
    err_set     = 1'b0;
    unique case (state)
      M_IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_nxt   = M_WAIT;
          waitcnt_nxt = 8'd1;
        end
      end
      M_WAIT: begin
        if (MemAckM) begin
          state_nxt   = M_IDLE;
          waitcnt_nxt = '0;
        end else if (waitcnt == WAIT_LAST) begin
          state_nxt   = M_IDLE;
          waitcnt_nxt = '0;
          err_set     = 1'b1;
        end else begin
          waitcnt_nxt = waitcnt + 8'd1;
        end
      end
      default: state_nxt = M_IDLE;
    endcase
  end

  // The abandon cycle releases the stall so the pipeline moves past the failed access.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      M_IDLE:  mem_stall = MemReqM && !MemAckM;
      M_WAIT:  mem_stall = !MemAckM && (waitcnt != WAIT_LAST);
      default: mem_stall = 1'b0;
    endcase
    StallF = ldr_stall | PCWrPendingF | mem_stall;
    StallD = ldr_stall | mem_stall;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushD = !mem_stall & (PCWrPendingF | PCSrcW | BranchTakenE);
    FlushE = !mem_stall & (ldr_stall | BranchTakenE);
  end

  perf_counter_sat #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (PerfClr),
    .inc     (StallF),
    .count   (StallCount)
  );

  perf_counter_sat #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (PerfClr),
    .inc     (FlushE),
    .count   (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MEM_TIMEOUT=4 and hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        PCWrPendingF, PCSrcW, BranchTakenE, MemReqM, MemAckM, PerfClr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [31:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .PerfClr(PerfClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCWrPendingF, PCSrcW, BranchTakenE, MemReqM, MemAckM, PerfClr} = '0;
  endtask

  task automatic check_mem_stall(input string tag, input logic exp);
    check({tag, "_StallF"}, 32'(StallF), 32'(exp));
    check({tag, "_StallD"}, 32'(StallD), 32'(exp));
    check({tag, "_StallE"}, 32'(StallE), 32'(exp));
    check({tag, "_StallM"}, 32'(StallM), 32'(exp));
    check({tag, "_FlushW"}, 32'(FlushW), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #3;
    check("rst_stallcnt", StallCount, 0);
    check("rst_flushcnt", FlushCount, 0);
    check("rst_memerr",   32'(MemErr), 0);
    check("rst_stallf",   32'(StallF), 0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Forwarding priority and R15 exclusion
    RegWriteM = 1; RegWriteW = 1; WA3M = 5; WA3W = 5; RA1E = 5; RA2E = 5; #1;
    check("fwdA_m_wins", 32'(ForwardAE), 32'h2);
    check("fwdB_m_wins", 32'(ForwardBE), 32'h2);
    RegWriteM = 0; #1;
    check("fwdA_w_only", 32'(ForwardAE), 32'h1);
    RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; #1;
    check("fwdA_pc", 32'(ForwardAE), 32'h0);
    WA3M = 5; WA3W = 7; RA2E = 7; #1;
    check("fwdB_w_match", 32'(ForwardBE), 32'h1);
    RegWriteW = 0; #1;
    check("fwdB_no_we", 32'(ForwardBE), 32'h0);

    // Load-use: one bubble
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 2; RA1D = 2; #1;
    check("lu_stallf", 32'(StallF), 1);
    check("lu_stalld", 32'(StallD), 1);
    check("lu_flushe", 32'(FlushE), 1);
    check("lu_stalle", 32'(StallE), 0);
    next_cycle();
    clear_inputs();
    RA1E = 2; WA3W = 2; RegWriteW = 1; #1;
    check("lu_after_fwd",   32'(ForwardAE), 32'h1);
    check("lu_after_stall", 32'(StallF), 0);
    check("lu_stallcnt", StallCount, 1);
    check("lu_flushcnt", FlushCount, 1);

    // Wait-state access: ack after three stall cycles
    next_cycle();
    clear_inputs();
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_mem_stall($sformatf("ws%0d", i), 1'b1);
      next_cycle();
    end
    MemAckM = 1; #1;
    check_mem_stall("ws_ack", 1'b0);
    next_cycle();
    // Zero-wait access from idle proves the FSM returned to M_IDLE
    #1;
    check_mem_stall("zw", 1'b0);
    check("ws_stallcnt", StallCount, 4);
    next_cycle();

    // Branch during memory stall is deferred until the ack cycle
    MemAckM = 0; BranchTakenE = 1; #1;
    check("br_stalle", 32'(StallE), 1);
    check("br_flushd_def", 32'(FlushD), 0);
    check("br_flushe_def", 32'(FlushE), 0);
    next_cycle();
    MemAckM = 1; #1;
    check("br_flushd_ack", 32'(FlushD), 1);
    check("br_flushe_ack", 32'(FlushE), 1);
    check("br_stalle_ack", 32'(StallE), 0);
    next_cycle();
    clear_inputs(); #1;
    check("br_flushcnt", FlushCount, 2);
    check("br_stallcnt", StallCount, 5);

    // Load-use together with taken branch: branch flushes D as well
    MemtoRegE = 1; RegWriteE = 1; WA3E = 3; RA2D = 3; BranchTakenE = 1; #1;
    check("lub_flushd", 32'(FlushD), 1);
    check("lub_flushe", 32'(FlushE), 1);
    check("lub_stallf", 32'(StallF), 1);
    next_cycle();
    check("lub_stallcnt", StallCount, 6);
    check("lub_flushcnt", FlushCount, 3);

    // Clear wins over a simultaneous event
    PerfClr = 1; #1;
    check("clr_event_on", 32'(StallF), 1);
    next_cycle();
    clear_inputs(); #1;
    check("clr_stallcnt", StallCount, 0);
    check("clr_flushcnt", FlushCount, 0);
    next_cycle();

    // Timeout with MEM_TIMEOUT=4: three stall cycles, then abandon
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_mem_stall($sformatf("to%0d", i), 1'b1);
      check($sformatf("to%0d_memerr", i), 32'(MemErr), 0);
      next_cycle();
    end
    #1;
    check_mem_stall("to_release", 1'b0);
    check("to_memerr_pre", 32'(MemErr), 0);
    next_cycle();
    MemReqM = 0; #1;
    check("to_memerr_set", 32'(MemErr), 1);
    check("to_stallf_idle", 32'(StallF), 0);
    check("to_stallcnt", StallCount, 3);
    next_cycle();
    next_cycle();
    check("to_memerr_sticky", 32'(MemErr), 1);

    // Reset while waiting: WAIT ignores MemReqM, IDLE does not, so dropping it tells them apart
    MemReqM = 1; #1;
    check("rw_stall_idle", 32'(StallE), 1);
    next_cycle();
    MemReqM = 0; #1;
    check("rw_in_wait", 32'(StallE), 1);
    reset_n = 1'b0; #1;
    check("rw_stalle", 32'(StallE), 0);
    check("rw_memerr", 32'(MemErr), 0);
    check("rw_stallcnt", StallCount, 0);
    check("rw_flushcnt", FlushCount, 0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    #1;
    check("rw_after_idle", 32'(StallE), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
